// File: rtl/load_store_unit.sv
// RV32I data-side load/store sequencer: word-aligned memory port, load byte
// extraction/extension, read-modify-write for sub-word stores, fault flagging.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_address,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            resp_illegal,
  output logic [XLEN-1:0] mem_address,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [15:0]     wdata_q;
  logic [XLEN-1:0] wbuf_q;
  logic [XLEN-1:0] rdata_q;
  logic            mis_q, ill_q;

  logic            accept;
  logic            req_ill, req_mis;
  logic [XLEN-1:0] aligned;
  logic [1:0]      lane;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;
  logic [3:0]      bmask;
  logic [XLEN-1:0] wrep;
  logic [XLEN-1:0] merged;

  // Request handshake: a request transfers on a cycle where req_valid and
  // req_ready are both high; req_ready is high only while idle and out of reset.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign aligned   = {addr_q[XLEN-1:2], 2'b00};
  assign lane      = addr_q[1:0];

  // Illegal takes priority: misaligned is only raised for a legal funct3.
  always_comb begin
    req_ill = 1'b0;
    req_mis = 1'b0;
    if (req_write) req_ill = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else           req_ill = req_funct3 inside {3'b011, 3'b110, 3'b111};
    if (!req_ill) begin
      case (req_funct3[1:0])
        2'b01:   req_mis = req_address[0];
        2'b10:   req_mis = |req_address[1:0];
        default: req_mis = 1'b0;
      endcase
    end
  end

  always_comb begin
    shifted  = mem_read_data >> {lane, 3'b000};
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = mem_read_data;
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  // Store lanes are replicated across the word so a byte mask picks them in place.
  always_comb begin
    if (funct3_q[1:0] == 2'b00) begin
      bmask = 4'b0001 << lane;
      wrep  = {4{wdata_q[7:0]}};
    end else begin
      bmask = 4'b0011 << lane;
      wrep  = {2{wdata_q[15:0]}};
    end
    merged = mem_read_data;
    for (int k = 0; k < 4; k++) begin
      if (bmask[k]) merged[8*k +: 8] = wrep[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_ill || req_mis)         state_d = RESP;
          else if (!req_write)            state_d = LOAD;
          else if (req_funct3 == 3'b010)  state_d = WRITE;
          else                            state_d = MERGE;
        end
      end
      LOAD:    state_d = RESP;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_address;
        wdata_q  <= req_wdata[15:0];
        wbuf_q   <= req_wdata;
        rdata_q  <= '0;
        mis_q    <= req_mis;
        ill_q    <= req_ill;
      end
      if (state_q == LOAD)  rdata_q <= load_ext;
      if (state_q == MERGE) wbuf_q  <= merged;
    end
  end

  always_comb begin
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    resp_illegal    = 1'b0;
    mem_address     = '0;
    mem_write_en    = 1'b0;
    mem_write_data  = '0;
    if (!rst) begin
      case (state_q)
        LOAD, MERGE: mem_address = aligned;
        WRITE: begin
          mem_address    = aligned;
          mem_write_en   = 1'b1;
          mem_write_data = wbuf_q;
        end
        RESP: begin
          resp_valid      = 1'b1;
          resp_rdata      = rdata_q;
          resp_misaligned = mis_q;
          resp_illegal    = ill_q;
        end
        default: ;
      endcase
    end
  end

endmodule
